alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 75 +++++++
 rtl/alu_arbiter_rr_arb2.sv | 45 ++++
 rtl/alu_arbiter.sv | 234 +++++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//
// Shared definitions for the ALU request arbiter and the control wrapper that
// sits above it:
//   * operand / result / counter widths
//   * opcode constants
//   * datapath control word (struct + per-opcode constants) and decoder
//   * FSM state encoding
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W = 6;    // operand width
    localparam int RES_W  = 12;   // datapath result width ({outm, out})
    localparam int OP_W   = 3;    // opcode width
    localparam int CNT_W  = 3;    // latency counter width (latencies 1..7)

    // Opcodes
    localparam logic [OP_W-1:0] OP_ADD     = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB     = 3'b001;
    localparam logic [OP_W-1:0] OP_AND     = 3'b010;
    localparam logic [OP_W-1:0] OP_OR      = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR     = 3'b100;
    localparam logic [OP_W-1:0] OP_CMP     = 3'b101;
    localparam logic [OP_W-1:0] OP_MUL     = 3'b110;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

    // Control word presented to the datapath. Field order matches the
    // packed concatenation {alu_sel, alu_mul, alu_mc, alu_mux}.
    typedef struct packed {
        logic       sel;   // 1 = ALU output path, 0 = multiplier/comparator
        logic       mul;   // multiply/compare select
        logic [1:0] mc;    // logic/arithmetic mode
        logic [3:0] mux;   // function select
    } ctrl_t;

    localparam ctrl_t CTRL_ADD  = '{sel: 1'b1, mul: 1'b0, mc: 2'b00, mux: 4'b0000};
    localparam ctrl_t CTRL_SUB  = '{sel: 1'b1, mul: 1'b0, mc: 2'b00, mux: 4'b0001};
    localparam ctrl_t CTRL_AND  = '{sel: 1'b1, mul: 1'b0, mc: 2'b01, mux: 4'b0000};
    localparam ctrl_t CTRL_OR   = '{sel: 1'b1, mul: 1'b0, mc: 2'b01, mux: 4'b0001};
    localparam ctrl_t CTRL_XOR  = '{sel: 1'b1, mul: 1'b0, mc: 2'b01, mux: 4'b0010};
    localparam ctrl_t CTRL_CMP  = '{sel: 1'b0, mul: 1'b1, mc: 2'b00, mux: 4'b0000};
    localparam ctrl_t CTRL_MUL  = '{sel: 1'b0, mul: 1'b0, mc: 2'b00, mux: 4'b0000};
    localparam ctrl_t CTRL_NONE = '{sel: 1'b0, mul: 1'b0, mc: 2'b00, mux: 4'b0000};

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return (op != OP_ILLEGAL);
    endfunction

    // Illegal opcodes map to CTRL_NONE; callers never load it into the
    // datapath registers, so the value only matters for completeness.
    function automatic ctrl_t op_to_ctrl(input logic [OP_W-1:0] op);
        ctrl_t c;
        c = CTRL_NONE;
        case (op)
            OP_ADD:  c = CTRL_ADD;
            OP_SUB:  c = CTRL_SUB;
            OP_AND:  c = CTRL_AND;
            OP_OR:   c = CTRL_OR;
            OP_XOR:  c = CTRL_XOR;
            OP_CMP:  c = CTRL_CMP;
            OP_MUL:  c = CTRL_MUL;
            default: c = CTRL_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//
// Two-requester round-robin grant. The grant is combinational from req; the
// pointer remembers which requester won last and advances only when the
// owner accepts the grant (accept high with a non-zero grant).
//
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset (requester 0 wins first tie)
//   req     in   [1:0] request bits
//   accept  in   grant is being taken this cycle; advance the pointer
//   grant   out  [1:0] one-hot grant (or zero when no request)
// -----------------------------------------------------------------------------
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    // Index of the requester granted most recently. Resetting it to 1 makes
    // requester 0 the preferred one on the first tie.
    logic last_reg;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_reg ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (accept && (grant != 2'b00)) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external ALU/multiplier/comparator datapath between two
// requesters. In IDLE a round-robin grant picks one requester; its opcode and
// operands are latched and driven to the datapath for a fixed number of
// cycles (MUL_LAT for MUL, ALU_LAT otherwise), after which dp_result is
// captured and offered as a response until the consumer accepts it.
// Illegal opcodes skip the datapath and respond with rsp_err=1, rsp_data=0.
//
// Parameters:
//   MUL_LAT  cycles the multiplier path is held before capture (1..7)
//   ALU_LAT  cycles the ALU/comparator paths are held before capture (1..7)
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req_valid / req_ready    [1:0] per-requester handshake
//   req{0,1}_op/_a/_b        per-requester opcode and operands
//   alu_a, alu_b             operands to the datapath (registered)
//   alu_mc, alu_mux,
//   alu_mul, alu_sel         control word to the datapath (registered)
//   dp_result                datapath result {outm[11:7], out[6:0]}
//   rsp_valid / rsp_ready    response handshake
//   rsp_id, rsp_err,
//   rsp_data                 owner, illegal-op flag, captured result
//   busy                     high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_mc,
    output logic [3:0]        alu_mux,
    output logic              alu_mul,
    output logic              alu_sel,
    input  logic [RES_W-1:0]  dp_result,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic              rsp_err,
    output logic [RES_W-1:0]  rsp_data,
    output logic              busy
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [DATA_W-1:0] alu_a_reg, alu_b_reg;
    ctrl_t             ctrl_reg;
    logic              owner_reg;
    logic              rsp_id_reg;
    logic              rsp_err_reg;
    logic [RES_W-1:0]  rsp_data_reg;

    // ------------------------------------------------------------------
    // Request selection
    // ------------------------------------------------------------------
    logic [OP_W-1:0]   req_op_arr [2];
    logic [DATA_W-1:0] req_a_arr  [2];
    logic [DATA_W-1:0] req_b_arr  [2];

    assign req_op_arr[0] = req0_op;
    assign req_op_arr[1] = req1_op;
    assign req_a_arr[0]  = req0_a;
    assign req_a_arr[1]  = req1_a;
    assign req_b_arr[0]  = req0_b;
    assign req_b_arr[1]  = req1_b;

    logic       grant_en;    // arbiter may grant this cycle
    logic [1:0] grant;
    logic       grant_fire;  // a request is transferred this cycle
    logic       grant_id;

    // Gating with rst_n keeps req_ready low while reset is held, even though
    // the state register already reads IDLE.
    assign grant_en = (state_reg == ST_IDLE) && rst_n;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req_valid),
        .accept (grant_en),
        .grant  (grant)
    );

    assign grant_fire = grant_en && (grant != 2'b00);
    assign grant_id   = grant[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = grant_en & grant[gi];
        end
    endgenerate

    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;
    ctrl_t             sel_ctrl;
    logic              sel_legal;
    logic [CNT_W-1:0]  sel_lat;

    assign sel_op    = req_op_arr[grant_id];
    assign sel_a     = req_a_arr[grant_id];
    assign sel_b     = req_b_arr[grant_id];
    assign sel_ctrl  = op_to_ctrl(sel_op);
    assign sel_legal = op_is_legal(sel_op);
    assign sel_lat   = (sel_op == OP_MUL) ? CNT_W'(MUL_LAT) : CNT_W'(ALU_LAT);

    // ------------------------------------------------------------------
    // FSM next-state
    // ------------------------------------------------------------------
    logic load_op;       // latch operands/control into the datapath regs
    logic capture;       // latch dp_result as the response
    logic take_illegal;  // respond immediately with an error

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        load_op      = 1'b0;
        capture      = 1'b0;
        take_illegal = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (grant_fire) begin
                    if (sel_legal) begin
                        load_op    = 1'b1;
                        cnt_next   = sel_lat;
                        state_next = ST_EXEC;
                    end else begin
                        take_illegal = 1'b1;
                        state_next   = ST_RESP;
                    end
                end
            end

            ST_EXEC: begin
                // The counter holds the number of EXEC cycles left including
                // this one; the last one (value 1) is the capture cycle. A
                // zero value cannot occur normally but is treated the same so
                // the FSM can never stall here.
                if (cnt_reg <= CNT_W'(1)) begin
                    capture    = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= '0;
            alu_a_reg    <= '0;
            alu_b_reg    <= '0;
            ctrl_reg     <= CTRL_NONE;
            owner_reg    <= 1'b0;
            rsp_id_reg   <= 1'b0;
            rsp_err_reg  <= 1'b0;
            rsp_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;

            // Datapath inputs only change on a legal grant, so they stay on
            // the last operation through EXEC, RESP and IDLE.
            if (load_op) begin
                alu_a_reg <= sel_a;
                alu_b_reg <= sel_b;
                ctrl_reg  <= sel_ctrl;
                owner_reg <= grant_id;
            end

            if (capture) begin
                rsp_data_reg <= dp_result;
                rsp_err_reg  <= 1'b0;
                rsp_id_reg   <= owner_reg;
            end else if (take_illegal) begin
                rsp_data_reg <= '0;
                rsp_err_reg  <= 1'b1;
                rsp_id_reg   <= grant_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_sel   = ctrl_reg.sel;
    assign alu_mul   = ctrl_reg.mul;
    assign alu_mc    = ctrl_reg.mc;
    assign alu_mux   = ctrl_reg.mux;
    assign rsp_valid = (state_reg == ST_RESP);
    assign rsp_id    = rsp_id_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_data  = rsp_data_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Drives two requesters, models the external datapath from the control word,
// and scoreboards every response against a reference computed from the
// opcode with plain arithmetic. Directed scenarios first, then random traffic.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int MUL_LAT_TB = 3;
    localparam int ALU_LAT_TB = 1;

    logic        clk;
    logic        rst_n;
    logic [1:0]  rv;
    logic [2:0]  rop [2];
    logic [5:0]  ra  [2];
    logic [5:0]  rb  [2];
    logic        rsp_ready;

    logic [1:0]  req_ready;
    logic [5:0]  alu_a, alu_b;
    logic [1:0]  alu_mc;
    logic [3:0]  alu_mux;
    logic        alu_mul, alu_sel;
    logic [11:0] dp_result;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [11:0] rsp_data;
    logic        busy;

    alu_arbiter #(.MUL_LAT(MUL_LAT_TB), .ALU_LAT(ALU_LAT_TB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (rv),
        .req_ready (req_ready),
        .req0_op   (rop[0]),
        .req0_a    (ra[0]),
        .req0_b    (rb[0]),
        .req1_op   (rop[1]),
        .req1_a    (ra[1]),
        .req1_b    (rb[1]),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_mc    (alu_mc),
        .alu_mux   (alu_mux),
        .alu_mul   (alu_mul),
        .alu_sel   (alu_sel),
        .dp_result (dp_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Datapath model: interprets the control word; unknown words give FFF.
    // ------------------------------------------------------------------
    function automatic logic [11:0] dp_model(input logic sel, input logic mul,
                                             input logic [1:0] mc, input logic [3:0] mux,
                                             input logic [5:0] a, input logic [5:0] b);
        logic [11:0] x;
        logic [11:0] y;
        logic [11:0] r;
        x = {6'b0, a};
        y = {6'b0, b};
        r = 12'hFFF;
        if (sel && !mul && mc == 2'b00 && mux == 4'h0)       r = x + y;
        else if (sel && !mul && mc == 2'b00 && mux == 4'h1)  r = (x - y) & 12'h07F;
        else if (sel && !mul && mc == 2'b01 && mux == 4'h0)  r = x & y;
        else if (sel && !mul && mc == 2'b01 && mux == 4'h1)  r = x | y;
        else if (sel && !mul && mc == 2'b01 && mux == 4'h2)  r = x ^ y;
        else if (!sel && mul && mc == 2'b00 && mux == 4'h0)  r = {9'b0, (a > b), (a == b), (a < b)};
        else if (!sel && !mul && mc == 2'b00 && mux == 4'h0) r = x * y;
        return r;
    endfunction

    assign dp_result = dp_model(alu_sel, alu_mul, alu_mc, alu_mux, alu_a, alu_b);

    // ------------------------------------------------------------------
    // Reference model (by opcode)
    // ------------------------------------------------------------------
    function automatic logic [11:0] ref_result(input logic [2:0] op, input logic [5:0] a,
                                               input logic [5:0] b);
        int ia;
        int ib;
        int r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = (ia - ib) & 127;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = (ia > ib ? 4 : 0) + (ia == ib ? 2 : 0) + (ia < ib ? 1 : 0);
            3'd6:    r = ia * ib;
            default: r = 0;
        endcase
        return 12'(r);
    endfunction

    // {sel, mul, mc, mux}
    function automatic logic [7:0] exp_ctrl(input logic [2:0] op);
        case (op)
            3'd0:    return 8'b1_0_00_0000;
            3'd1:    return 8'b1_0_00_0001;
            3'd2:    return 8'b1_0_01_0000;
            3'd3:    return 8'b1_0_01_0001;
            3'd4:    return 8'b1_0_01_0010;
            3'd5:    return 8'b0_1_00_0000;
            3'd6:    return 8'b0_0_00_0000;
            default: return 8'h00;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Checking infrastructure
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic        id;
        logic        err;
        logic [11:0] data;
        int          grant_cyc;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          grant_log[$];
    int          cyc = 0;
    logic        last_g = 1'b1;
    logic        rsp_open = 1'b0;
    exp_t        cur;
    logic [19:0] exp_alu = '0;   // {ctrl, a, b} the datapath should be seeing

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [1:0] exp_g;
        exp_t       e;
        int         idx;
        if (!rst_n) begin
            sb.delete();
            last_g   = 1'b1;
            rsp_open = 1'b0;
            exp_alu  = '0;
        end else begin
            cyc++;
            check("alu_hold", {alu_sel, alu_mul, alu_mc, alu_mux, alu_a, alu_b}, exp_alu);

            if (rsp_valid) begin
                if (!rsp_open) begin
                    if (sb.size() == 0) begin
                        check("rsp_unexpected", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("rsp_id", rsp_id, cur.id);
                        check("rsp_err", rsp_err, cur.err);
                        check("rsp_data", rsp_data, cur.data);
                        check("rsp_latency", cyc - cur.grant_cyc, cur.lat);
                    end
                end else begin
                    check("rsp_stable", {rsp_id, rsp_err, rsp_data}, {cur.id, cur.err, cur.data});
                end
                rsp_open = !rsp_ready;
            end else begin
                if (rsp_open) check("rsp_dropped", 1, 0);
                rsp_open = 1'b0;
            end

            if (busy) begin
                check("ready_when_busy", req_ready, 2'b00);
            end else begin
                // Not-last-granted wins a tie; a lone request always wins.
                exp_g = (rv == 2'b11) ? (last_g ? 2'b01 : 2'b10) : rv;
                check("grant", req_ready, exp_g);
                if (exp_g != 2'b00) begin
                    idx         = exp_g[1] ? 1 : 0;
                    e.id        = exp_g[1];
                    e.err       = (rop[idx] == 3'b111);
                    e.data      = ref_result(rop[idx], ra[idx], rb[idx]);
                    e.grant_cyc = cyc;
                    e.lat       = e.err ? 1 : ((rop[idx] == 3'd6 ? MUL_LAT_TB : ALU_LAT_TB) + 1);
                    sb.push_back(e);
                    grant_log.push_back(idx);
                    last_g = exp_g[1];
                    if (!e.err) exp_alu = {exp_ctrl(rop[idx]), ra[idx], rb[idx]};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic wait_grant(input int id);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready[id] && n < 100);
        if (n >= 100) check("grant_timeout", 1, 0);
        @(posedge clk);
        #1;
        rv[id] = 1'b0;
    endtask

    task automatic issue(input int id, input logic [2:0] op, input logic [5:0] a,
                         input logic [5:0] b);
        rop[id] = op;
        ra[id]  = a;
        rb[id]  = b;
        rv[id]  = 1'b1;
        wait_grant(id);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0 || rv != 2'b00) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    function automatic logic [37:0] all_outs();
        return {req_ready, alu_a, alu_b, alu_mc, alu_mux, alu_mul, alu_sel,
                rsp_valid, rsp_id, rsp_err, rsp_data, busy};
    endfunction

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        logic [1:0] g;
        int         issued;
        int         n;

        rst_n     = 1'b1;
        rv        = 2'b00;
        rsp_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rop[i] = 3'd0;
            ra[i]  = 6'd0;
            rb[i]  = 6'd0;
        end

        // Reset with a request already waiting: nothing may be driven.
        #1 rst_n = 1'b0;
        rop[0] = 3'd0; ra[0] = 6'd5; rb[0] = 6'd9; rv[0] = 1'b1;
        #2 check("reset_outputs", all_outs(), 38'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        rsp_ready = 1'b1;

        // ADD 5+9 from requester 0 -> 0x00E
        wait_grant(0);
        wait_idle();

        // Both requesters valid continuously -> 0,1,0,1
        do_reset();
        grant_log.delete();
        rop[0] = 3'd1; ra[0] = 6'd40; rb[0] = 6'd50;
        rop[1] = 3'd4; ra[1] = 6'd21; rb[1] = 6'd63;
        rv = 2'b11;
        n = 0;
        while (grant_log.size() < 4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 rv = 2'b00;
        if (grant_log.size() < 4) check("rr_timeout", 1, 0);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("rr_sequence", grant_log[i], i % 2);
        wait_idle();

        // MUL 7*6 -> 42, response 4 cycles after grant
        issue(0, 3'd6, 6'd7, 6'd6);
        wait_idle();

        // Illegal opcode from requester 1
        issue(1, 3'b111, 6'd12, 6'd34);
        wait_idle();

        // Consumer stalls 10 cycles while requester 1 waits
        rsp_ready = 1'b0;
        issue(0, 3'd4, 6'h2A, 6'h15);
        rop[1] = 3'd0; ra[1] = 6'd63; rb[1] = 6'd63; rv[1] = 1'b1;
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("stall_rsp_timeout", 1, 0);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        wait_grant(1);
        wait_idle();

        // Reset in the middle of a MUL; a fresh request is pending across it
        issue(0, 3'd6, 6'd33, 6'd50);
        rop[0] = 3'd0; ra[0] = 6'd3; rb[0] = 6'd4; rv[0] = 1'b1;
        #1 rst_n = 1'b0;
        #1 check("midexec_reset_outputs", all_outs(), 38'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        wait_grant(0);
        wait_idle();

        // Random traffic
        issued = 0;
        for (int c = 0; c < 4000 &&
             (issued < 80 || rv != 2'b00 || busy || rsp_valid || sb.size() != 0); c++) begin
            @(negedge clk);
            g = req_ready & rv;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (g[i]) rv[i] = 1'b0;
                if (!rv[i] && issued < 80 && $urandom_range(0, 2) == 0) begin
                    rop[i] = 3'($urandom_range(0, 7));
                    ra[i]  = 6'($urandom_range(0, 63));
                    rb[i]  = 6'($urandom_range(0, 63));
                    rv[i]  = 1'b1;
                    issued++;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("drain_scoreboard", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
